// File: rtl/gal_olmc_bank.sv
`default_nettype none
// ============================================================================
//  Module   : gal_olmc_bank
//  Purpose  : N-channel GAL output logic macrocell bank. Each channel is set
//             at elaboration to registered/combinational and true/inverted
//             polarity. Its output enable is either a product term or forced
//             on. The bank provides a shared async reset, a synchronous preset
//             and feedback outputs into the AND array.
//  Revision : 1.0  initial release
//
//  Parameters
//    WIDTH       number of channels (1..24)
//    REGISTERED  bit i = 1 : channel i output comes from its flop
//    INVERTED    bit i = 1 : pin is the complement of the core value
//    OE_FORCE    bit i = 1 : channel i is always enabled, E[i] is ignored
//
//  Ports
//    C      in   clock, rising edge
//    AR_N   in   asynchronous reset, active-low (clears every flop)
//    SP     in   synchronous preset, active-high (sets registered flops)
//    A      in   [WIDTH] sum-of-products result per channel
//    E      in   [WIDTH] output-enable product term per channel
//    Y      io   [WIDTH] pin; driven when enabled, else high-Z
//    FB     out  [WIDTH] feedback into the AND array
//
//  Optional feature (macro GAL_OLMC_PRELOAD_EN)
//    PL_EN  in   preload shift enable; overrides SP and A, tri-states all pins
//    PL_DI  in   serial data into Q[0]
//    PL_DO  out  serial data out, always Q[WIDTH-1]
// ============================================================================
module gal_olmc_bank #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] REGISTERED = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] INVERTED   = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] OE_FORCE   = {WIDTH{1'b0}}
) (
  input  logic             C,
  input  logic             AR_N,
  input  logic             SP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] E,
  inout  wire  [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] FB
`ifdef GAL_OLMC_PRELOAD_EN
  ,
  input  logic             PL_EN,
  input  logic             PL_DI,
  output logic             PL_DO
`endif
);

  logic [WIDTH-1:0] r_q;          // one flop per channel
  logic [WIDTH-1:0] w_capture;    // next Q in normal operation
  logic [WIDTH-1:0] w_q_next;     // next Q including preload
  logic [WIDTH-1:0] w_v;          // core value before polarity
  logic [WIDTH-1:0] w_pin;        // value presented on the pin
  logic [WIDTH-1:0] w_oe;         // effective output enable
  logic             w_pl_active;  // preload shifting in progress

`ifdef GAL_OLMC_PRELOAD_EN
  // Shift chain formed by appending PL_DI below Q; the low WIDTH bits are the
  // shifted value. Written this way so WIDTH=1 needs no special case.
  logic [WIDTH:0] w_chain;

  assign w_chain     = {r_q, PL_DI};
  assign w_pl_active = PL_EN;
  assign PL_DO       = r_q[WIDTH-1];
`else
  assign w_pl_active = 1'b0;
`endif

  // Registered channels load 1 on preset, else A. Combinational channels
  // keep whatever the flop holds: 0 after reset, or a preloaded value.
  always_comb begin
    w_capture = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (REGISTERED[i]) begin
        w_capture[i] = SP | A[i];
      end
    end
  end

  always_comb begin
    w_q_next = w_capture;
`ifdef GAL_OLMC_PRELOAD_EN
    if (PL_EN) begin
      w_q_next = w_chain[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge C or negedge AR_N) begin
    if (!AR_N) begin
      r_q <= {WIDTH{1'b0}};
    end else begin
      r_q <= w_q_next;
    end
  end

  // Output path. Combinational channels see A with zero latency. Reset only
  // touches Q, so those pins do not move when AR_N toggles.
  assign w_v   = (REGISTERED & r_q) | (~REGISTERED & A);
  assign w_pin = w_v ^ INVERTED;
  assign w_oe  = (OE_FORCE | E) & ~{WIDTH{w_pl_active}};

  // Registered feedback is Q before inversion. Combinational feedback reads the
  // resolved pin, so an external driver is visible while the pin is tri-stated.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    assign Y[i]  = w_oe[i] ? w_pin[i] : 1'bz;
    assign FB[i] = REGISTERED[i] ? r_q[i] : Y[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_gal_olmc_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gal_olmc_bank
//  Purpose  : Directed self-checking bench for gal_olmc_bank. It uses three
//             instances:
//               dut_a  WIDTH=4, all registered, INVERTED=0101, all forced on
//               dut_b  WIDTH=4, REGISTERED=1100, true polarity, E-controlled
//               dut_c  WIDTH=1, registered, inverted, forced on
//             High-Z is detected by driving the pin from the bench with the
//             opposite of what the DUT would drive when enabled.
//             The preload test is compiled when GAL_OLMC_PRELOAD_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gal_olmc_bank;

  logic clk;
  int   n_tests;
  int   n_fail;

  // dut_a stimulus
  logic       rst_n_a, sp_a;
  logic [3:0] a_a, e_a, drv_en_a, drv_val_a, fb_a;
  wire  [3:0] y_a;
  // dut_b stimulus
  logic       rst_n_b, sp_b;
  logic [3:0] a_b, e_b, drv_en_b, drv_val_b, fb_b;
  wire  [3:0] y_b;
  // dut_c stimulus
  logic       rst_n_c, sp_c;
  logic [0:0] a_c, e_c, fb_c;
  wire  [0:0] y_c;

`ifdef GAL_OLMC_PRELOAD_EN
  logic pl_en, pl_di, pl_do_a, pl_do_b, pl_do_c;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign y_a[i] = drv_en_a[i] ? drv_val_a[i] : 1'bz;
    assign y_b[i] = drv_en_b[i] ? drv_val_b[i] : 1'bz;
  end

  gal_olmc_bank #(
    .WIDTH(4), .REGISTERED(4'b1111), .INVERTED(4'b0101), .OE_FORCE(4'b1111)
  ) dut_a (
    .C(clk), .AR_N(rst_n_a), .SP(sp_a), .A(a_a), .E(e_a), .Y(y_a), .FB(fb_a)
`ifdef GAL_OLMC_PRELOAD_EN
    , .PL_EN(pl_en), .PL_DI(pl_di), .PL_DO(pl_do_a)
`endif
  );

  gal_olmc_bank #(
    .WIDTH(4), .REGISTERED(4'b1100), .INVERTED(4'b0000), .OE_FORCE(4'b0000)
  ) dut_b (
    .C(clk), .AR_N(rst_n_b), .SP(sp_b), .A(a_b), .E(e_b), .Y(y_b), .FB(fb_b)
`ifdef GAL_OLMC_PRELOAD_EN
    , .PL_EN(1'b0), .PL_DI(1'b0), .PL_DO(pl_do_b)
`endif
  );

  gal_olmc_bank #(
    .WIDTH(1), .REGISTERED(1'b1), .INVERTED(1'b1), .OE_FORCE(1'b1)
  ) dut_c (
    .C(clk), .AR_N(rst_n_c), .SP(sp_c), .A(a_c), .E(e_c), .Y(y_c), .FB(fb_c)
`ifdef GAL_OLMC_PRELOAD_EN
    , .PL_EN(1'b0), .PL_DI(1'b0), .PL_DO(pl_do_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n_a  = 1'b0; sp_a = 1'b0; a_a = 4'b1111; e_a = 4'b0000;
    drv_en_a = 4'b0000; drv_val_a = 4'b0000;
    rst_n_b  = 1'b0; sp_b = 1'b0; a_b = 4'b0000; e_b = 4'b1111;
    drv_en_b = 4'b0000; drv_val_b = 4'b0000;
    rst_n_c  = 1'b0; sp_c = 1'b0; a_c = 1'b0; e_c = 1'b0;
`ifdef GAL_OLMC_PRELOAD_EN
    pl_en = 1'b0; pl_di = 1'b0;
`endif
    #2;

    // ---- reset state --------------------------------------------------
    check("a_rst_y",  y_a,  4'b0101);
    check("a_rst_fb", fb_a, 4'b0000);
    check("c_rst_y",  {3'b000, y_c}, 4'b0001);
    tick();
    check("a_rst_edge_fb", fb_a, 4'b0000);   // A=1111 must not load in reset

    // ---- release and capture -----------------------------------------
    rst_n_a = 1'b1; a_a = 4'b0011;
    rst_n_b = 1'b1;
    rst_n_c = 1'b1; a_c = 1'b1;
    tick();
    check("a_cap_y",  y_a,  4'b0110);
    check("a_cap_fb", fb_a, 4'b0011);
    check("c_cap_y",  {3'b000, y_c},  4'b0000);
    check("c_cap_fb", {3'b000, fb_c}, 4'b0001);

    a_a = 4'b1001;
    tick();
    check("a_cap2_fb", fb_a, 4'b1001);
    check("a_cap2_y",  y_a,  4'b1100);

    // ---- preset beats data -------------------------------------------
    sp_a = 1'b1; a_a = 4'b0000;
    tick();
    check("a_sp_fb", fb_a, 4'b1111);
    check("a_sp_y",  y_a,  4'b1010);
    sp_a = 1'b0;

    // ---- async reset between edges -----------------------------------
    #2 rst_n_a = 1'b0;
    #1;
    check("a_ar_mid_fb", fb_a, 4'b0000);
    check("a_ar_mid_y",  y_a,  4'b0101);
    #1 rst_n_a = 1'b1;

    // ---- async reset coincident with clock edge ----------------------
    sp_a = 1'b1;
    tick();
    check("a_sp2_fb", fb_a, 4'b1111);
    @(negedge clk);
    #5 rst_n_a = 1'b0;                        // same timestep as posedge
    #1;
    check("a_ar_edge_fb", fb_a, 4'b0000);
    rst_n_a = 1'b1; sp_a = 1'b0;

    // ---- mixed modes: combinational bits move without an edge --------
    #1 a_b = 4'b1010;
    #1;
    check("b_mix_comb", {2'b00, y_b[1:0]}, 4'b0010);
    check("b_mix_reg",  {2'b00, y_b[3:2]}, 4'b0000);
    tick();
    check("b_mix_edge_y",  y_b,  4'b1010);
    check("b_mix_edge_fb", fb_b, 4'b1010);

    // ---- output enable and tristate ----------------------------------
    a_b = 4'b1111;
    tick();
    check("b_oe_all_y", y_b, 4'b1111);
    e_b = 4'b0001; drv_en_b = 4'b1110; drv_val_b = 4'b0000;
    #1;
    check("b_oe_y",     y_b, 4'b0001);
    check("b_oe_fbreg", {2'b00, fb_b[3:2]}, 4'b0011);
    a_b = 4'b0000; drv_val_b = 4'b0010;
    #1;
    check("b_ext1_fb1", {3'b000, fb_b[1]}, 4'b0001);
    a_b = 4'b0010; drv_val_b = 4'b0000;
    #1;
    check("b_ext0_fb1", {3'b000, fb_b[1]}, 4'b0000);
    drv_en_b = 4'b0000;

`ifdef GAL_OLMC_PRELOAD_EN
    // ---- preload shift chain on dut_a (Q currently 0) ----------------
    // Q[0] takes PL_DI each edge, so the first bit ends up in Q[3].
    pl_en = 1'b1; drv_en_a = 4'b1111; drv_val_a = 4'b0000;
    pl_di = 1'b1; tick();
    pl_di = 1'b0; tick();
    pl_di = 1'b1; tick();
    check("a_pl_do3", {3'b000, pl_do_a}, 4'b0000);
    check("a_pl_fb3", fb_a, 4'b0101);
    pl_di = 1'b1; tick();
    check("a_pl_fb4", fb_a, 4'b1011);
    check("a_pl_do4", {3'b000, pl_do_a}, 4'b0001);
    check("a_pl_hiz", y_a, 4'b0000);          // pins would be 1110 if driven
    pl_en = 1'b0; drv_en_a = 4'b0000;
    #1;
    check("a_pl_vis_y", y_a, 4'b1110);
    tick();
    check("a_pl_resume_fb", fb_a, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
